// File: rtl/irq_ctrl_pkg.sv
// Shared register map and mode encoding for the APB interrupt/event controller.
package irq_ctrl_pkg;

    // Word offsets, as seen on PADDR[5:2]
    localparam logic [3:0] REG_MASK    = 4'h0;
    localparam logic [3:0] REG_PENDING = 4'h1;
    localparam logic [3:0] REG_SET     = 4'h2;
    localparam logic [3:0] REG_CLEAR   = 4'h3;
    localparam logic [3:0] REG_MODE    = 4'h4;
    localparam logic [3:0] REG_ID      = 4'h5;
    localparam int unsigned NUM_REGS   = 6;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder returning {valid, id}.
module irq_prio_enc #(
    parameter int N   = 32,
    parameter int IDW = 5
) (
    input  logic [N-1:0]   vec_i,
    output logic           valid_o,
    output logic [IDW-1:0] id_o
);

    always_comb begin
        valid_o = |vec_i;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) id_o = IDW'(i);
        end
    end

endmodule

// File: rtl/apb_irq_controller.sv
// APB interrupt/event controller: per-line edge/level capture, mask, SW set/clear, lowest-index arbitration.
// Define IRQ_INPUT_SYNC_EN to pass line_i through a 2-flop synchronizer before capture.
module apb_irq_controller #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int ID_WIDTH       = 5
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      line_i,
    output logic                      irq_req_o,
    output logic [ID_WIDTH-1:0]       irq_id_o,
    input  logic                      irq_ack_i,
    input  logic [ID_WIDTH-1:0]       irq_ack_id_i,
    output logic                      any_pending_o
);
    import irq_ctrl_pkg::*;

    localparam int OFF_W = (APB_ADDR_WIDTH < 12) ? APB_ADDR_WIDTH : 12;

    logic [NUM_LINES-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic [NUM_LINES-1:0] line_q, line_d;
    logic                 irq_req_q, irq_req_d;
    logic [ID_WIDTH-1:0]  irq_id_q, irq_id_d;

    logic [NUM_LINES-1:0] line_s, rise, hw_set, ack_vec, set_sw, clr_sw, masked, wr_data;
    logic [9:0]           word_off;
    logic [3:0]           reg_sel;
    logic                 acc_err, wr_en, enc_valid;
    logic [ID_WIDTH-1:0]  enc_id;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign unused_bits = ^{PADDR, PWDATA};

`ifdef IRQ_INPUT_SYNC_EN
    logic [NUM_LINES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = line_i;
`endif

    // Offset is checked across the whole 4KB window so aliases of the map raise an error
    always_comb begin
        word_off              = '0;
        word_off[OFF_W-3:0]   = PADDR[OFF_W-1:2];
        reg_sel               = word_off[3:0];
        acc_err               = (word_off >= 10'(NUM_REGS));
        wr_en                 = PSEL & PENABLE & PWRITE & ~acc_err;
        wr_data               = PWDATA[NUM_LINES-1:0];
    end

    always_comb begin
        rise    = line_s & ~line_q;
        hw_set  = '0;
        ack_vec = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            hw_set[i]  = (irq_mode_e'(mode_q[i]) == MODE_EDGE) ? rise[i] : line_s[i];
            ack_vec[i] = irq_ack_i && (irq_ack_id_i == ID_WIDTH'(i));
        end
        set_sw = (wr_en && reg_sel == REG_SET)   ? wr_data : '0;
        clr_sw = (wr_en && reg_sel == REG_CLEAR) ? wr_data : '0;

        // Set wins over clear so a same-cycle event is never lost
        pend_d = hw_set | set_sw | (pend_q & ~(clr_sw | ack_vec));
        mask_d = (wr_en && reg_sel == REG_MASK) ? wr_data : mask_q;
        mode_d = (wr_en && reg_sel == REG_MODE) ? wr_data : mode_q;
        line_d = line_s;

        masked    = pend_q & mask_q;
        irq_req_d = enc_valid;
        irq_id_d  = enc_valid ? enc_id : irq_id_q;
    end

    irq_prio_enc #(
        .N   (NUM_LINES),
        .IDW (ID_WIDTH)
    ) u_prio_enc (
        .vec_i   (masked),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q    <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            line_q    <= '0;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            line_q    <= line_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MASK:    rdata[NUM_LINES-1:0] = mask_q;
            REG_PENDING: rdata[NUM_LINES-1:0] = pend_q;
            REG_MODE:    rdata[NUM_LINES-1:0] = mode_q;
            REG_ID: begin
                rdata[ID_WIDTH-1:0] = irq_id_q;
                rdata[31]           = irq_req_q;
            end
            default:     rdata = '0;
        endcase
    end

    assign PRDATA        = (PSEL && !acc_err) ? rdata : '0;
    assign PREADY        = 1'b1;
    assign PSLVERR       = PSEL & PENABLE & acc_err;
    assign irq_req_o     = irq_req_q;
    assign irq_id_o      = irq_id_q;
    assign any_pending_o = |masked;

endmodule
